// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
//   state_t  : sequencer FSM states
//   TT_*     : 2-input truth tables, bit i = gate output for vector i = {a,b}
//   num_vec  : number of input vectors for an n-input gate
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic int num_vec(input int n);
    return int'(32'd1 << n);
  endfunction

endpackage

// File: rtl/gate_truth_table_sequencer_settle_counter.sv
// settle_counter: 8-bit loadable down-counter used to time the gate settle
// window. The counter stops at zero rather than wrapping.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over en)
//   en        : decrement by one while non-zero
//   load_val  : value loaded on load
//   last      : registered flag, high while the count equals 1
module settle_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       last
);

  logic [7:0] count_r;
  logic       last_r;

  // Count register; last_r tracks (count_r == 1) one step ahead so it is a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
      last_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_val;
      last_r  <= (load_val == 8'd1);
    end else if (en && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
      last_r  <= (count_r == 8'd2);
    end else begin
      count_r <= count_r;
      last_r  <= last_r;
    end
  end

  assign last = last_r;

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// gate_truth_table_sequencer: walks an external combinational gate through
// every input vector, waits SETTLE_CYCLES, samples the gate output and
// compares it against EXPECTED.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : run request, only looked at in IDLE
//   abort     : cancel a run in progress (also blocks start in IDLE)
//   gate_in   : vector driven to the gate under test (0 in IDLE)
//   gate_out  : gate under test output
//   busy      : run in progress
//   done      : one-cycle pulse at the end of a completed run
//   pass      : all vectors matched; held until the next run is accepted
//   observed  : captured truth table, bit i = sample for vector i
//   fail_idx  : lowest failing vector index (0 when none failed)
//   err_count : number of mismatching vectors
module gate_truth_table_sequencer
  import gate_test_pkg::*;
#(
  parameter int                         N_IN          = 2,
  parameter int                         SETTLE_CYCLES = 4,
  parameter logic [num_vec(N_IN)-1:0]   EXPECTED      = TT_NAND
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_IN-1:0]            gate_in,
  input  logic                       gate_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [num_vec(N_IN)-1:0]   observed,
  output logic [N_IN-1:0]            fail_idx,
  output logic [N_IN:0]              err_count
);

  localparam int              NUM_VEC     = num_vec(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NUM_VEC - 1);
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t               state_r;
  state_t               state_s;
  logic [N_IN-1:0]      idx_r;
  logic [N_IN-1:0]      gate_in_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic [NUM_VEC-1:0]   observed_r;
  logic [N_IN-1:0]      fail_idx_r;
  logic [N_IN:0]        err_count_r;

  logic                 accept_s;
  logic                 abort_s;
  logic                 sample_s;
  logic                 finish_s;
  logic                 cnt_load_s;
  logic                 cnt_en_s;
  logic                 cnt_last_s;
  logic                 mismatch_s;
  logic [N_IN:0]        err_next_s;

  settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (SETTLE_LOAD),
    .last     (cnt_last_s)
  );

  // Comparison of the current sample and the error count it would produce.
  always_comb begin
    mismatch_s = (gate_out != EXPECTED[idx_r]);
    if (mismatch_s) begin
      err_next_s = err_count_r + (N_IN+1)'(1);
    end else begin
      err_next_s = err_count_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus the per-edge action strobes for the datapath.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    abort_s    = 1'b0;
    sample_s   = 1'b0;
    finish_s   = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // abort outranks start so a held abort keeps the block parked
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          state_s  = DRIVE;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (abort) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_load_s = 1'b1;
          state_s    = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_en_s = 1'b1;
          if (cnt_last_s) begin
            state_s = SAMPLE;
          end else begin
            state_s = SETTLE;
          end
        end
      end
      SAMPLE: begin
        // an abort here drops the sample: sample_s stays low
        if (abort) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          sample_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            finish_s = 1'b1;
            state_s  = IDLE;
          end else begin
            state_s = DRIVE;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Result/output registers, updated from the FSM strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= '0;
      gate_in_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      observed_r  <= '0;
      fail_idx_r  <= '0;
      err_count_r <= '0;
    end else if (abort_s || accept_s) begin
      // both clear the results; they differ only in whether a run begins
      idx_r       <= '0;
      gate_in_r   <= '0;
      busy_r      <= accept_s;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      observed_r  <= '0;
      fail_idx_r  <= '0;
      err_count_r <= '0;
    end else if (sample_s) begin
      observed_r[idx_r] <= gate_out;
      err_count_r       <= err_next_s;
      // err_count_r still zero means this is the first (lowest) failure
      if (mismatch_s && (err_count_r == (N_IN+1)'(0))) begin
        fail_idx_r <= idx_r;
      end
      if (finish_s) begin
        idx_r     <= '0;
        gate_in_r <= '0;
        busy_r    <= 1'b0;
        done_r    <= 1'b1;
        pass_r    <= (err_next_s == (N_IN+1)'(0));
      end else begin
        idx_r     <= idx_r + N_IN'(1);
        gate_in_r <= idx_r + N_IN'(1);
        done_r    <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign gate_in   = gate_in_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign observed  = observed_r;
  assign fail_idx  = fail_idx_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench for gate_truth_table_sequencer. dut uses the defaults
// (2 inputs, 4 settle cycles, NAND table); dut0 uses SETTLE_CYCLES=0.
// Edge k means the k-th rising edge after the edge that accepted start.
module tb_gate_truth_table_sequencer;
  import gate_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] gate_in;
  logic       gate_out;
  logic       busy, done, pass;
  logic [3:0] observed;
  logic [1:0] fail_idx;
  logic [2:0] err_count;

  logic       start0, abort0;
  logic [1:0] gate_in0;
  logic       gate_out0;
  logic       busy0, done0, pass0;
  logic [3:0] observed0;
  logic [1:0] fail_idx0;
  logic [2:0] err_count0;

  int         mode;        // 0 = NAND, 1 = stuck-at-1, 2 = AND
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n;
  int         pulses;
  logic [1:0] gi_hist [0:200];

  always #5 clk = ~clk;

  // Gate-under-test models, written from the gate function, not the table.
  always_comb begin
    case (mode)
      0:       gate_out = ~(gate_in[1] & gate_in[0]);
      1:       gate_out = 1'b1;
      2:       gate_out = gate_in[1] & gate_in[0];
      default: gate_out = 1'b0;
    endcase
  end
  assign gate_out0 = ~(gate_in0[1] & gate_in0[0]);

  gate_truth_table_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
    .pass(pass), .observed(observed), .fail_idx(fail_idx), .err_count(err_count)
  );

  gate_truth_table_sequencer #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECTED(TT_NAND)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .gate_in(gate_in0), .gate_out(gate_out0), .busy(busy0), .done(done0),
    .pass(pass0), .observed(observed0), .fail_idx(fail_idx0), .err_count(err_count0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected DUT shows done; n = ticks taken, -1 on timeout.
  task automatic wait_done(input bit sel, output int cnt);
    cnt = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (sel == 1'b0) gi_hist[k] = gate_in;
      if (((sel == 1'b1) ? done0 : done) === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  // One-cycle start pulse on dut; returns just after the accepting edge.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0; mode = 0;
    #1 rst = 1'b1;
    #2;
    check("rst_busy",     busy,      32'd0);
    check("rst_done",     done,      32'd0);
    check("rst_pass",     pass,      32'd0);
    check("rst_observed", observed,  32'd0);
    check("rst_gate_in",  gate_in,   32'd0);
    check("rst_fail_idx", fail_idx,  32'd0);
    check("rst_err",      err_count, 32'd0);
    check("rst_busy0",    busy0,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Correct NAND gate with default timing.
    pulse_start();
    check("nand_busy",  busy,    32'd1);
    check("nand_gi0",   gate_in, 32'd0);
    wait_done(1'b0, n);
    check("nand_latency", n, 32'd24);
    check("nand_gi_e5",  gi_hist[5],  32'd0);
    check("nand_gi_e6",  gi_hist[6],  32'd1);
    check("nand_gi_e11", gi_hist[11], 32'd1);
    check("nand_gi_e12", gi_hist[12], 32'd2);
    check("nand_gi_e18", gi_hist[18], 32'd3);
    check("nand_gi_e23", gi_hist[23], 32'd3);
    check("nand_pass",     pass,      32'd1);
    check("nand_observed", observed,  32'h7);
    check("nand_err",      err_count, 32'd0);
    check("nand_fail_idx", fail_idx,  32'd0);
    check("nand_busy_end", busy,      32'd0);
    check("nand_gi_idle",  gate_in,   32'd0);
    tick();
    check("nand_done_1cyc", done, 32'd0);
    check("nand_pass_held", pass, 32'd1);

    // Stuck-at-1 gate: only vector 3 mismatches.
    mode = 1;
    pulse_start();
    check("stuck_pass_clr", pass, 32'd0);
    wait_done(1'b0, n);
    check("stuck_latency",  n,         32'd24);
    check("stuck_observed", observed,  32'hF);
    check("stuck_pass",     pass,      32'd0);
    check("stuck_err",      err_count, 32'd1);
    check("stuck_fail_idx", fail_idx,  32'd3);

    // AND gate against a NAND table: every vector mismatches.
    mode = 2;
    pulse_start();
    wait_done(1'b0, n);
    check("and_observed", observed,  32'h8);
    check("and_err",      err_count, 32'd4);
    check("and_fail_idx", fail_idx,  32'd0);
    check("and_pass",     pass,      32'd0);
    mode = 0;

    // SETTLE_CYCLES=0: done at edge 8, a start at edge 3 is ignored.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("s0_busy", busy0, 32'd1);
    tick();
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(1'b1, n);
    check("s0_latency_from_e3", n, 32'd5);
    check("s0_pass",     pass0,     32'd1);
    check("s0_observed", observed0, 32'h7);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done0 === 1'b1) pulses++;
    end
    check("s0_single_done", pulses, 32'd0);
    check("s0_idle", busy0, 32'd0);

    // Abort sampled at edge 11 (raised after edge 10).
    pulse_start();
    repeat (10) tick();
    check("abort_pre_obs", observed, 32'h1);
    check("abort_pre_gi",  gate_in,  32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",     busy,      32'd0);
    check("abort_gi",       gate_in,   32'd0);
    check("abort_observed", observed,  32'd0);
    check("abort_err",      err_count, 32'd0);
    check("abort_pass",     pass,      32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    // abort and start together in IDLE: abort wins.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_idle", busy, 32'd0);
    pulse_start();
    wait_done(1'b0, n);
    check("post_abort_latency",  n,        32'd24);
    check("post_abort_pass",     pass,     32'd1);
    check("post_abort_observed", observed, 32'h7);

    // Async reset during vector 1 settle, then back-to-back runs with start held.
    pulse_start();
    repeat (9) tick();
    check("prerst_busy", busy,     32'd1);
    check("prerst_gi",   gate_in,  32'd1);
    check("prerst_obs",  observed, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",     busy,     32'd0);
    check("midrst_gi",       gate_in,  32'd0);
    check("midrst_observed", observed, 32'd0);
    check("midrst_pass",     pass,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    tick();
    check("b2b_busy", busy, 32'd1);
    wait_done(1'b0, n);
    check("b2b_first", n, 32'd24);
    wait_done(1'b0, n);
    check("b2b_spacing", n, 32'd25);
    check("b2b_pass", pass, 32'd1);
    start = 1'b0;
    tick();
    check("b2b_stop", busy, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name: gate_truth_table_sequencer

Overview:
- Controller that sequences an external combinational logic gate through every input combination and compares each output against a parameterised truth table.
- Waits a programmable settle time before sampling each output.
- Reports pass/fail, the observed truth table, the first failing vector and the error count.
- Sits between the board's start push-button/debouncer and the gate-under-test instance; results drive LEDs.

Parameters:
N_IN, 2, number of gate inputs (legal 1..4); NUM_VEC = 2**N_IN
SETTLE_CYCLES, 4, clock cycles between driving a vector and sampling it (legal 0..255)
EXPECTED, 4'b0111, expected gate output; bit i = output for input vector i (default = NAND, vector i = {a,b})

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a test run; level-sampled in IDLE only
abort  in  1  synchronous abort of a run in progress
gate_in  out  N_IN  input vector driven to the gate under test
gate_out  in  1  output of the gate under test
busy  out  1  high while a run is in progress (any state except IDLE)
done  out  1  one-cycle pulse when a run completes
pass  out  1  1 = all vectors matched EXPECTED; held until the next run is accepted
observed  out  NUM_VEC  captured truth table; bit i = gate_out sampled for vector i
fail_idx  out  N_IN  lowest failing vector index; 0 when pass=1
err_count  out  N_IN+1  number of mismatching vectors

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, settle counter=0, gate_in=0, busy=0, done=0, pass=0, observed=0, fail_idx=0, err_count=0.
- All outputs are registered; gate_in = idx outside IDLE and 0 in IDLE.
- States:
  - IDLE:
    - start=1 at an edge -> DRIVE.
    - On that same edge: idx=0, observed=0, err_count=0, fail_idx=0, pass=0.
  - DRIVE:
    - gate_in=idx; the settle counter loads SETTLE_CYCLES.
    - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
  - SETTLE:
    - The counter decrements each cycle; it spends exactly SETTLE_CYCLES cycles in SETTLE.
    - -> SAMPLE when the counter reaches 1.
  - SAMPLE: at the edge leaving SAMPLE:
    - observed[idx] <= gate_out.
    - On mismatch with EXPECTED[idx]: err_count += 1, and fail_idx <= idx if this is the first mismatch.
    - If idx = NUM_VEC-1 -> IDLE, with done=1 and pass = (final err_count==0).
    - Otherwise idx += 1 -> DRIVE.
- Latency: done rises NUM_VEC*(SETTLE_CYCLES+2) edges after the edge that accepted start (24 with defaults).
- done is high for exactly one cycle.
- Boundaries:
  - start while busy: ignored; no restart, no queueing.
  - start held high: a new run is accepted at the first edge back in IDLE, one cycle after done rises.
  - abort=1 while busy: -> IDLE at the next edge; no done; pass=0, observed/err_count/fail_idx cleared to 0; gate_in=0.
  - abort=1 and start=1 in IDLE: abort has priority; no run starts.
  - abort in the SAMPLE cycle: the sample is discarded.
  - rst mid-run: immediate return to reset values.
  - idx wraps only via the terminal check; no counter overflow.
  - err_count max = NUM_VEC, which fits in N_IN+1 bits.

Decomposition:
- Package gate_test_pkg holds:
  - state enum {IDLE, DRIVE, SETTLE, SAMPLE};
  - function num_vec(n) = 2**n;
  - truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One sub-module, settle_counter: 8-bit loadable down-counter with load, en, and a registered last (count==1) flag.

Test Plan:
- Correct NAND, defaults: pulse start one cycle -> gate_in steps 00,01,10,11, each held 6 cycles; done at edge 24; pass=1, observed=4'b0111, err_count=0, fail_idx=0.
- Gate stuck-at-1 with EXPECTED=TT_NAND -> observed=4'b1111, pass=0, err_count=1, fail_idx=3.
- AND gate with EXPECTED=TT_NAND -> observed=4'b1000, err_count=4, fail_idx=0, pass=0.
- SETTLE_CYCLES=0 -> done at edge 8; a second start pulse while busy at edge 3 is ignored, with exactly one done.
- Assert abort at edge 10 -> busy=0 at edge 11, no done, observed=0, gate_in=0; a following start gives a clean 24-cycle run.
- Assert rst mid-SETTLE -> all outputs 0 asynchronously; after release, start held high produces back-to-back runs with done 25 cycles apart.
